// File: rtl/xup_shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter-width helper used by the top and by testbenches.
package xup_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  // Width of the shift counter; a 2-bit register still needs one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/xup_shift_next.sv
// Combinational next-value mux for the shift register. Produces the value q
// would take if the operation executes, plus a flag marking shift modes.
module xup_shift_next
  import xup_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             is_shift
);

  // Lower WIDTH-1 bits shared by every right-moving operation.
  logic [WIDTH-2:0] right_core;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_right_core
      assign right_core[gi] = q[gi+1];
    end
  endgenerate

  // Decode mode into the candidate next value; reserved code falls back to hold.
  always_comb begin
    q_next   = q;
    is_shift = 1'b0;
    case (mode)
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], sin};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {sin, right_core};
        is_shift = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q[0], right_core};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        q_next   = {q[WIDTH-1], right_core};
        is_shift = 1'b1;
      end
      default: begin
        q_next   = q;
        is_shift = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/xup_shift_reg_en.sv
// Parametrised universal shift register with clock enable, synchronous clear,
// shift counter and a one-cycle word-complete pulse.
module xup_shift_reg_en
  import xup_shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  // Simulation-only update delay; registered updates here are zero-delay, so
  // it folds into a constant and never changes cycle behaviour.
  parameter int               DELAY     = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [2:0]                  mode,
  input  logic [WIDTH-1:0]            d,
  input  logic                        sin,
  output logic [WIDTH-1:0]            q,
  output logic                        sout,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        done
);

  localparam int CNT_W = cnt_width(WIDTH) + 0 * DELAY;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic             is_shift;

  xup_shift_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q       (q_reg),
    .mode    (mode),
    .sin     (sin),
    .d       (d),
    .q_next  (q_next),
    .is_shift(is_shift)
  );

  // Register, counter and done pulse: clr beats enable, enable beats hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (clr) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (en) begin
      q_reg <= q_next;
      if (mode == MODE_LOAD) begin
        cnt_reg  <= '0;
        done_reg <= 1'b0;
      end else if (is_shift) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg  <= '0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg  <= cnt_reg + CNT_W'(1);
          done_reg <= 1'b0;
        end
      end else begin
        done_reg <= 1'b0;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  // Serial output taps the MSB for left-moving modes, the LSB otherwise.
  always_comb begin
    sout = q_reg[0];
    if ((mode == MODE_SHL) || (mode == MODE_ROL)) begin
      sout = q_reg[WIDTH-1];
    end
  end

  assign q    = q_reg;
  assign cnt  = cnt_reg;
  assign done = done_reg;

endmodule

// File: doc/xup_shift_reg_en.md
Name: xup_shift_reg_en

Overview:
- Parametrised universal shift register. Generalises the single-bit enabled D flip-flop to a WIDTH-bit register.
- Modes: hold, parallel load, logical/arithmetic shift, rotate. Adds async active-low reset, synchronous clear, and a shift counter with a word-complete pulse.
- Used as the shared building block for serialisers/deserialisers (UART, SPI, LED chains) in lab designs.

Parameters:
- WIDTH, 8: register width in bits; legal range >= 2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q by reset_n and by clr.
- DELAY, 3: simulation-only intra-assignment delay (ns) applied to every registered update. Set to 0 for synthesis; it must not alter cycle behaviour.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable. When low, all state holds except clr and done.
- clr  in  1  synchronous clear. Independent of en.
- mode  in  3  operation select; see Behaviour.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input for SHL/SHR.
- q  out  WIDTH  register contents.
- sout  out  1  serial output: q[WIDTH-1] in modes SHL/ROL, q[0] in all other modes. Combinational from q and mode.
- cnt  out  CNT_W  shifts since last load/clear. CNT_W = (WIDTH<=2) ? 1 : $clog2(WIDTH).
- done  out  1  registered one-cycle pulse marking a completed word.

Behaviour:
- Reset: reset_n low asynchronously forces q=RESET_VAL, cnt=0, done=0. Release is synchronous to the next clk edge; no operation executes on the release edge unless reset_n is high at that edge.
- Priority at each rising edge: clr > en&mode > hold.
- clr=1: q<=RESET_VAL, cnt<=0, done<=0, regardless of en or mode.
- en=0 (clr=0): q and cnt hold; done<=0.
- en=1, mode decode (q' = next q):
  - 000 HOLD: q'=q; cnt holds.
  - 001 LOAD: q'=d; cnt<=0.
  - 010 SHL: q'={q[WIDTH-2:0],sin}.
  - 011 SHR: q'={sin,q[WIDTH-1:1]}.
  - 100 ROL: q'={q[WIDTH-2:0],q[WIDTH-1]}; sin ignored.
  - 101 ROR: q'={q[0],q[WIDTH-1:1]}; sin ignored.
  - 110 ASR: q'={q[WIDTH-1],q[WIDTH-1:1]}; sin ignored.
  - 111: reserved; behaves as HOLD.
- Shift ops are modes 010-110. Each executed shift does the following:
  - If cnt==WIDTH-1: cnt<=0 (wrap) and done<=1.
  - Otherwise: cnt<=cnt+1 and done<=0.
- Non-shift ops (HOLD, LOAD, reserved, en=0, clr) drive done<=0.
- done is therefore high exactly one cycle after the edge completing WIDTH consecutive shift operations since the last LOAD/clr/wrap. Interleaved HOLD cycles do not reset cnt.
- Latency: q, cnt, done update one cycle after the sampled inputs. sout follows q and mode combinationally, with zero latency.
- Simultaneous clr and en=1 shift: clr wins; no shift, no done.
- LOAD on the same edge cnt would wrap: LOAD wins; cnt=0, done=0.
- reset_n asserted mid-word: everything returns to reset values immediately. The partial word is discarded and no done is produced.
- No X propagation: with reset_n high and inputs known, all outputs are known after the first edge following reset.

Decomposition:
- Shared package xup_shift_pkg holds:
  - mode localparams MODE_HOLD=3'b000, MODE_LOAD=3'b001, MODE_SHL=3'b010, MODE_SHR=3'b011, MODE_ROL=3'b100, MODE_ROR=3'b101, MODE_ASR=3'b110;
  - a function returning CNT_W from WIDTH.
- One natural sub-module, xup_shift_next: a combinational next-state mux (q, mode, sin, d -> q_next, is_shift) instantiated by the top. Counter, done, and register logic stay in the top.

Test Plan (WIDTH=8, RESET_VAL=0, DELAY=0):
- Reset: hold reset_n=0 mid-cycle with en=1, mode=LOAD, d=8'hFF -> q=8'h00, cnt=0, done=0 immediately and while low. First edge after release loads 8'hFF.
- Load then SHL with sin pattern 1,0,1,1,0,0,1,0 over 8 cycles from q=8'h00 -> q=8'hB2. cnt steps 1..7 then 0. done=1 only in the cycle after the 8th shift. sout tracks q[7] each cycle.
- q=8'h81, ROR once -> 8'hC0; ROL twice from 8'h81 -> 8'h06. ASR from 8'h80 three times -> 8'hF0, with sin=0 throughout.
- en toggling during an 8-shift word (3 shifts, 4 cycles en=0, 5 shifts) -> q frozen while en=0, done low during the gap, done pulses once after the 8th shift.
- Simultaneous events: clr=1 with mode=SHL at cnt=7 -> q=8'h00, cnt=0, no done. LOAD at cnt=7 -> q=d, cnt=0, no done. mode=3'b111 -> q and cnt unchanged, done=0.
- Reset mid-word: after 5 shifts, pulse reset_n low for 1 ns -> q=0, cnt=0. Eight subsequent shifts produce exactly one done pulse.
